// File: rtl/vmac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vmac_pkg
//  Description : Shared constants, sequencer state encoding and lane slice
//                helpers for the 4-lane 16x16+32 vector MAC sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package vmac_pkg;

    // Datapath geometry
    localparam int LANES = 4;    // vector lanes
    localparam int EW    = 16;   // operand element width
    localparam int AW    = 32;   // accumulator width per lane
    localparam int LW    = 8;    // command length width

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Extract accumulator lane idx from a packed {lane3..lane0} vector
    function automatic logic [AW-1:0] acc_lane(input logic [LANES*AW-1:0] vec,
                                               input int unsigned         idx);
        return vec[idx*AW +: AW];
    endfunction

    // Extract operand lane idx from a packed {x3..x0} vector
    function automatic logic [EW-1:0] op_lane(input logic [LANES*EW-1:0] vec,
                                              input int unsigned         idx);
        return vec[idx*EW +: EW];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vmac_mask_merge.sv
`default_nettype none
// ============================================================================
//  Module      : vmac_mask_merge
//  Description : Per-lane select between the MAC result and the current
//                accumulator. Disabled lanes keep their accumulator so they
//                finish holding c_init whatever the MAC drives for them.
//  Revision    : 1.0 - initial release
// ============================================================================
module vmac_mask_merge
    import vmac_pkg::*;
(
    input  logic [LANES-1:0]    mask,     // latched lane enables
    input  logic [LANES*AW-1:0] acc,      // current accumulators
    input  logic [LANES*AW-1:0] y,        // MAC result vector
    output logic [LANES*AW-1:0] merged    // next accumulators
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign merged[i*AW +: AW] = mask[i] ? acc_lane(y, i) : acc_lane(acc, i);
    end

endmodule
`default_nettype wire

// File: rtl/vmac_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module      : vmac_accum_seq
//  Description : Command sequencer for the 4-lane vector MAC. Accepts one
//                K-beat accumulation command at a time, streams each operand
//                beat straight through to the MAC, folds each MAC result back
//                into the accumulator and returns the final vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module vmac_accum_seq
    import vmac_pkg::*;
(
    input  logic                clk,
    input  logic                rst,            // synchronous, active-low

    // Command stream
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LW-1:0]       cmd_len,
    input  logic                cmd_signed,
    input  logic [LANES-1:0]    cmd_mask,
    input  logic [LANES*AW-1:0] cmd_c_init,

    // Operand stream
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [LANES*EW-1:0] op_a,
    input  logic [LANES*EW-1:0] op_b,

    // MAC request side
    output logic                mac_in_valid,
    input  logic                mac_in_ready,
    output logic [LANES*EW-1:0] mac_a_vec,
    output logic [LANES*EW-1:0] mac_b_vec,
    output logic [LANES*AW-1:0] mac_c_vec,
    output logic [LANES-1:0]    mac_lane_mask,
    output logic                mac_op_signed,

    // MAC response side
    input  logic                mac_out_valid,
    output logic                mac_out_ready,
    input  logic [LANES*AW-1:0] mac_y_vec,

    // Result stream
    output logic                res_valid,
    input  logic                res_ready,
    output logic [LANES*AW-1:0] res_y,
    output logic [LW-1:0]       res_beats,

    output logic                busy
);

    // ------------------------------------------------------------------
    // State and latched command configuration
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [LANES*AW-1:0]   r_acc;         // running accumulators
    logic [LW-1:0]         r_cnt;         // beats still to retire
    logic [LW-1:0]         r_len;         // beats requested by command
    logic                  r_signed;
    logic [LANES-1:0]      r_mask;

    // Registered handshake / status outputs
    logic                  r_cmd_ready;
    logic                  r_busy;
    logic                  r_mac_out_ready;
    logic                  r_res_valid;

    // Combinational helpers
    logic                  w_in_issue;
    logic                  w_cmd_fire;
    logic                  w_op_fire;
    logic                  w_mac_ret;
    logic                  w_res_fire;
    logic                  w_last_beat;
    logic [LANES*AW-1:0]   w_acc_merged;

    assign w_in_issue  = (r_state == ST_ISSUE);
    assign w_cmd_fire  = cmd_valid & r_cmd_ready;
    // Operands are never buffered: a beat is consumed exactly when the MAC takes it
    assign w_op_fire   = w_in_issue & op_valid & mac_in_ready;
    // MAC results are only consumed while waiting; stray out_valid elsewhere is ignored
    assign w_mac_ret   = r_mac_out_ready & mac_out_valid;
    assign w_res_fire  = r_res_valid & res_ready;
    assign w_last_beat = (r_cnt == LW'(1));

    // ------------------------------------------------------------------
    // Lane-masked write-back of the MAC result
    // ------------------------------------------------------------------
    vmac_mask_merge u_mask_merge (
        .mask   (r_mask),
        .acc    (r_acc),
        .y      (mac_y_vec),
        .merged (w_acc_merged)
    );

    // ------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------
    assign cmd_ready     = r_cmd_ready;
    assign busy          = r_busy;

    assign mac_in_valid  = w_in_issue & op_valid;
    assign op_ready      = w_in_issue & mac_in_ready;
    assign mac_a_vec     = op_a;
    assign mac_b_vec     = op_b;
    assign mac_c_vec     = r_acc;
    assign mac_lane_mask = r_mask;
    assign mac_op_signed = r_signed;

    assign mac_out_ready = r_mac_out_ready;

    assign res_valid     = r_res_valid;
    assign res_y         = r_acc;
    assign res_beats     = r_len;

    // ------------------------------------------------------------------
    // Sequencer FSM: state, accumulators, beat counter and registered flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_acc           <= '0;
            r_cnt           <= '0;
            r_len           <= '0;
            r_signed        <= 1'b0;
            r_mask          <= '0;
            r_cmd_ready     <= 1'b1;
            r_busy          <= 1'b0;
            r_mac_out_ready <= 1'b0;
            r_res_valid     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_len       <= cmd_len;
                        r_cnt       <= cmd_len;
                        r_signed    <= cmd_signed;
                        r_mask      <= cmd_mask;
                        r_acc       <= cmd_c_init;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        // A zero-length command completes without touching the MAC
                        if (cmd_len != '0) begin
                            r_state     <= ST_ISSUE;
                        end else begin
                            r_state     <= ST_DONE;
                            r_res_valid <= 1'b1;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (w_op_fire) begin
                        r_state         <= ST_WAIT;
                        r_mac_out_ready <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (w_mac_ret) begin
                        r_acc           <= w_acc_merged;
                        r_cnt           <= r_cnt - LW'(1);
                        r_mac_out_ready <= 1'b0;
                        if (w_last_beat) begin
                            r_state     <= ST_DONE;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state     <= ST_ISSUE;
                        end
                    end
                end

                ST_DONE: begin
                    // Result retires here; a command offered in the same cycle
                    // is taken on the following cycle from IDLE
                    if (w_res_fire) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state         <= ST_IDLE;
                    r_cmd_ready     <= 1'b1;
                    r_busy          <= 1'b0;
                    r_mac_out_ready <= 1'b0;
                    r_res_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vmac_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vmac_accum_seq
//  Description : Self-checking bench for vmac_accum_seq with a behavioural
//                MAC stand-in and an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vmac_accum_seq;
    import vmac_pkg::*;

    localparam int VW = LANES*AW;
    localparam int OW = LANES*EW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_signed;
    logic [LW-1:0]    cmd_len;
    logic [LANES-1:0] cmd_mask;
    logic [VW-1:0]    cmd_c_init;
    logic             op_valid, op_ready;
    logic [OW-1:0]    op_a, op_b;
    logic             mac_in_valid, mac_in_ready;
    logic [OW-1:0]    mac_a_vec, mac_b_vec;
    logic [VW-1:0]    mac_c_vec;
    logic [LANES-1:0] mac_lane_mask;
    logic             mac_op_signed;
    logic             mac_out_valid, mac_out_ready;
    logic [VW-1:0]    mac_y_vec;
    logic             res_valid, res_ready;
    logic [VW-1:0]    res_y;
    logic [LW-1:0]    res_beats;
    logic             busy;

    vmac_accum_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_signed(cmd_signed), .cmd_mask(cmd_mask), .cmd_c_init(cmd_c_init),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_in_valid(mac_in_valid), .mac_in_ready(mac_in_ready),
        .mac_a_vec(mac_a_vec), .mac_b_vec(mac_b_vec), .mac_c_vec(mac_c_vec),
        .mac_lane_mask(mac_lane_mask), .mac_op_signed(mac_op_signed),
        .mac_out_valid(mac_out_valid), .mac_out_ready(mac_out_ready),
        .mac_y_vec(mac_y_vec),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_beats(res_beats), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_mac_in = 0;        // cycles with mac_in_valid high
    bit mac_stall = 1'b0;    // enables random MAC backpressure/latency

    logic [OW-1:0] beat_a [256];
    logic [OW-1:0] beat_b [256];

    // Lane product mod 2^AW, signed or unsigned
    function automatic logic [AW-1:0] lane_prod(input logic [EW-1:0] a,
                                                input logic [EW-1:0] b,
                                                input bit sgn);
        int sa, sb;
        int unsigned ua, ub;
        if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            return AW'(sa * sb);
        end
        ua = int'(a);
        ub = int'(b);
        return AW'(ua * ub);
    endfunction

    // Reference: enabled lanes get c_init + sum of products, others keep c_init
    function automatic logic [VW-1:0] model(input int len, input bit sgn,
                                            input logic [LANES-1:0] mask,
                                            input logic [VW-1:0] c);
        logic [VW-1:0] r;
        r = c;
        for (int l = 0; l < LANES; l++)
            if (mask[l])
                for (int k = 0; k < len; k++)
                    r[l*AW +: AW] = r[l*AW +: AW] +
                        lane_prod(beat_a[k][l*EW +: EW], beat_b[k][l*EW +: EW], sgn);
        return r;
    endfunction

    // Count issued MAC requests
    always @(negedge clk) if (rst === 1'b1 && mac_in_valid === 1'b1) n_mac_in <= n_mac_in + 1;

    // MAC stand-in: one request at a time; disabled lanes return garbage
    initial begin : mac_model
        logic [VW-1:0] y;
        int lat, guard;
        mac_in_ready  = 1'b0;
        mac_out_valid = 1'b0;
        mac_y_vec     = '0;
        forever begin
            do begin
                @(posedge clk); #1;
                mac_in_ready = mac_stall ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
            end while (!(mac_in_valid === 1'b1 && mac_in_ready === 1'b1));
            for (int l = 0; l < LANES; l++) begin
                if (mac_lane_mask[l])
                    y[l*AW +: AW] = mac_c_vec[l*AW +: AW] +
                        lane_prod(mac_a_vec[l*EW +: EW], mac_b_vec[l*EW +: EW], mac_op_signed);
                else
                    y[l*AW +: AW] = AW'($urandom);
            end
            @(posedge clk); #1;
            mac_in_ready = 1'b0;
            lat = mac_stall ? $urandom_range(0, 3) : 0;
            repeat (lat) begin @(posedge clk); #1; end
            mac_out_valid = 1'b1;
            mac_y_vec     = y;
            guard = 0;
            @(negedge clk);
            while (mac_out_ready !== 1'b1 && guard < 200) begin
                guard++;
                @(negedge clk);
            end
            @(posedge clk); #1;
            mac_out_valid = 1'b0;
            mac_y_vec     = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Drive one command with operands from beat_a/beat_b and collect the result
    task automatic run_cmd(input int len, input bit sgn, input logic [LANES-1:0] mask,
                           input logic [VW-1:0] c, input bit gaps, input int hold,
                           output logic [VW-1:0] y, output logic [LW-1:0] beats,
                           output bit ok, output bit stable);
        int guard;
        ok = 1'b1; stable = 1'b1; y = '0; beats = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_len = LW'(len); cmd_signed = sgn;
        cmd_mask = mask; cmd_c_init = c;
        guard = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1) begin
            if (++guard > 100) begin ok = 1'b0; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_len = LW'($urandom); cmd_c_init = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < len && ok; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            op_valid = 1'b1; op_a = beat_a[k]; op_b = beat_b[k];
            guard = 0;
            @(negedge clk);
            while (op_ready !== 1'b1) begin
                if (++guard > 100) begin ok = 1'b0; break; end
                @(negedge clk);
            end
            @(posedge clk); #1;
            op_valid = 1'b0; op_a = OW'({$urandom, $urandom}); op_b = OW'({$urandom, $urandom});
        end
        guard = 0;
        @(negedge clk);
        while (ok && res_valid !== 1'b1) begin
            if (++guard > 100) begin ok = 1'b0; break; end
            @(negedge clk);
        end
        y = res_y; beats = res_beats;
        repeat (hold) begin
            @(negedge clk);
            if (res_y !== y || res_valid !== 1'b1) stable = 1'b0;
        end
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            cmd_valid = 1'($urandom); cmd_len = LW'($urandom); cmd_c_init = {$urandom, $urandom, $urandom, $urandom};
            op_valid = 1'($urandom); res_ready = 1'($urandom);
            @(negedge clk);
            n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
            n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b expected 0", res_valid); else n_pass++;
            n_checks++; if (mac_in_valid !== 1'b0) $display("FAIL reset_mac_in_valid: got %b expected 0", mac_in_valid); else n_pass++;
        end
        @(posedge clk); #1;
        rst = 1'b1; cmd_valid = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL post_reset_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (mac_out_ready !== 1'b0) $display("FAIL post_reset_mac_out_ready: got %b expected 0", mac_out_ready); else n_pass++;
    endtask

    task automatic test_unsigned();
        logic [VW-1:0] y; logic [LW-1:0] beats; bit ok, st;
        for (int k = 0; k < 3; k++) begin
            beat_a[k] = {16'd4, 16'd3, 16'd2, 16'd1};
            beat_b[k] = {16'd4, 16'd3, 16'd2, 16'd1};
        end
        run_cmd(3, 1'b0, 4'hF, '0, 1'b0, 0, y, beats, ok, st);
        n_checks++; if (!ok) $display("FAIL unsigned_timeout: got timeout expected completion"); else n_pass++;
        n_checks++; if (y !== {32'd48, 32'd27, 32'd12, 32'd3}) $display("FAIL unsigned_res_y: got %h expected %h", y, {32'd48, 32'd27, 32'd12, 32'd3}); else n_pass++;
        n_checks++; if (beats !== LW'(3)) $display("FAIL unsigned_res_beats: got %0d expected 3", beats); else n_pass++;
    endtask

    task automatic test_signed();
        logic [VW-1:0] y, c; logic [LW-1:0] beats; bit ok, st;
        c = {4{32'd10}};
        for (int k = 0; k < 2; k++) begin
            beat_a[k] = {4{16'hFFFF}};
            beat_b[k] = {4{16'd5}};
        end
        run_cmd(2, 1'b1, 4'hF, c, 1'b0, 0, y, beats, ok, st);
        n_checks++; if (!ok) $display("FAIL signed_timeout: got timeout expected completion"); else n_pass++;
        n_checks++; if (y !== '0) $display("FAIL signed_res_y: got %h expected 0", y); else n_pass++;
        n_checks++; if (y !== model(2, 1'b1, 4'hF, c)) $display("FAIL signed_model: got %h expected %h", y, model(2, 1'b1, 4'hF, c)); else n_pass++;
    endtask

    task automatic test_mask();
        logic [VW-1:0] y, c; logic [LW-1:0] beats; bit ok, st;
        c = {32'd4, 32'd3, 32'd2, 32'd1};
        beat_a[0] = {4{16'd2}};
        beat_b[0] = {4{16'd2}};
        run_cmd(1, 1'b0, 4'b0101, c, 1'b0, 0, y, beats, ok, st);
        n_checks++; if (!ok) $display("FAIL mask_timeout: got timeout expected completion"); else n_pass++;
        n_checks++; if (y !== {32'd4, 32'd7, 32'd2, 32'd5}) $display("FAIL mask_res_y: got %h expected %h", y, {32'd4, 32'd7, 32'd2, 32'd5}); else n_pass++;
        n_checks++; if (beats !== LW'(1)) $display("FAIL mask_res_beats: got %0d expected 1", beats); else n_pass++;
    endtask

    task automatic test_len0();
        logic [VW-1:0] c; int n0;
        c = {4{32'h0000_1234}};
        @(posedge clk); #1;
        n0 = n_mac_in;
        cmd_valid = 1'b1; cmd_len = '0; cmd_signed = 1'b0; cmd_mask = 4'hF; cmd_c_init = c;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL len0_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b1) $display("FAIL len0_res_valid: got %b expected 1", res_valid); else n_pass++;
        n_checks++; if (res_y !== c) $display("FAIL len0_res_y: got %h expected %h", res_y, c); else n_pass++;
        n_checks++; if (res_beats !== '0) $display("FAIL len0_res_beats: got %0d expected 0", res_beats); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL len0_busy: got %b expected 1", busy); else n_pass++;
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b0) $display("FAIL len0_retire: got %b expected 0", res_valid); else n_pass++;
        n_checks++; if (n_mac_in !== n0) $display("FAIL len0_no_mac: got %0d requests expected %0d", n_mac_in, n0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] c1, c2;
        c1 = {$urandom, $urandom, $urandom, $urandom};
        c2 = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_len = '0; cmd_mask = 4'($urandom); cmd_c_init = c1;
        @(negedge clk);
        @(posedge clk); #1;
        cmd_c_init = c2; res_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL b2b_cmd_ready_done: got %b expected 0", cmd_ready); else n_pass++;
        n_checks++; if (res_y !== c1) $display("FAIL b2b_res1: got %h expected %h", res_y, c1); else n_pass++;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b0) $display("FAIL b2b_no_bypass_valid: got %b expected 0", res_valid); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_idle_ready: got %b expected 1", cmd_ready); else n_pass++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b1 || res_y !== c2) $display("FAIL b2b_res2: got %b/%h expected 1/%h", res_valid, res_y, c2); else n_pass++;
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] y, c, e; logic [LW-1:0] beats; bit ok, st, sgn;
        logic [LANES-1:0] m; int len;
        mac_stall = 1'b1;
        for (int t = 0; t < 4; t++) begin
            len = $urandom_range(1, 6);
            sgn = 1'($urandom);
            m   = 4'($urandom);
            c   = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < len; k++) begin
                beat_a[k] = OW'({$urandom, $urandom});
                beat_b[k] = OW'({$urandom, $urandom});
            end
            e = model(len, sgn, m, c);
            run_cmd(len, sgn, m, c, 1'b1, 10, y, beats, ok, st);
            n_checks++; if (!ok) $display("FAIL bp_timeout[%0d]: got timeout expected completion", t); else n_pass++;
            n_checks++; if (y !== e) $display("FAIL bp_res_y[%0d]: got %h expected %h", t, y, e); else n_pass++;
            n_checks++; if (beats !== LW'(len)) $display("FAIL bp_res_beats[%0d]: got %0d expected %0d", t, beats, len); else n_pass++;
            n_checks++; if (!st) $display("FAIL bp_stable[%0d]: got changing result expected stable", t); else n_pass++;
        end
        c = {4{32'hFFFF_FFFF}};
        beat_a[0] = {4{16'hFFFF}};
        beat_b[0] = {4{16'hFFFF}};
        run_cmd(1, 1'b0, 4'hF, c, 1'b1, 10, y, beats, ok, st);
        n_checks++; if (y !== {4{32'hFFFE_0000}}) $display("FAIL wrap_res_y: got %h expected %h", y, {4{32'hFFFE_0000}}); else n_pass++;
        n_checks++; if (!ok || !st) $display("FAIL wrap_handshake: got ok=%b stable=%b expected 1/1", ok, st); else n_pass++;
        mac_stall = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL bp_end_idle: got busy=%b ready=%b expected 0/1", busy, cmd_ready); else n_pass++;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_signed = 1'b0; cmd_mask = '0;
        cmd_c_init = '0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_mask();
        test_len0();
        test_back_to_back();
        test_backpressure();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
